// File: rtl/alu_seq_ctrl_if.sv
// Requester/datapath bundle for alu_seq_ctrl.
// master = requester + datapath side, slave = controller.
interface alu_seq_ctrl_if;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [31:0] INSTR;
  logic [15:0] K_IN;
  logic [9:0]  DADDR_IN;
  logic [15:0] Y_KMx_IN;
  logic [9:0]  DAddr;
  logic        Y_X_Kmx_Sel;
  logic [1:0]  Shifter_Sel;
  logic [3:0]  ALUC_IN;
  logic        CY_IN;
  logic [5:0]  SEL_A_RB;
  logic [5:0]  SEL_B_RB;
  logic [5:0]  C_SEL_RB;
  logic        Rd;
  logic        Wr;
  logic        CY_OUT;
  logic        DONE;
  logic        ERR;
  logic        CY_FLAG;

  modport master (
    output INSTR_VALID, INSTR, K_IN, DADDR_IN, CY_OUT,
    input  INSTR_READY, Y_KMx_IN, DAddr, Y_X_Kmx_Sel,
    input  Shifter_Sel, ALUC_IN, CY_IN, SEL_A_RB,
    input  SEL_B_RB, C_SEL_RB, Rd, Wr, DONE, ERR, CY_FLAG
  );

  modport slave (
    input  INSTR_VALID, INSTR, K_IN, DADDR_IN, CY_OUT,
    output INSTR_READY, Y_KMx_IN, DAddr, Y_X_Kmx_Sel,
    output Shifter_Sel, ALUC_IN, CY_IN, SEL_A_RB,
    output SEL_B_RB, C_SEL_RB, Rd, Wr, DONE, ERR, CY_FLAG
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle ALU sequencer: latches one op word and
// steps EXEC -> (MEMRD|MEMWR) -> WB driving datapath controls.
module alu_seq_ctrl (
  input  logic         CLK,
  input  logic         RST,
  alu_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MEMRD,
    S_MEMWR,
    S_WB
  } state_t;

  state_t      r_state;
  state_t      w_nxt;
  logic [27:0] r_instr;
  logic [15:0] r_k;
  logic [9:0]  r_daddr;
  logic        r_cy;
  logic        w_acc;
  logic [1:0]  w_mem;

  // op word bits [3:0] carry no meaning, so only [31:4] is kept
  assign w_acc = bus.INSTR_VALID && (r_state == S_IDLE);
  assign w_mem = r_instr[20:19];
  assign bus.CY_FLAG = r_cy;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_instr <= '0;
      r_k     <= '0;
      r_daddr <= '0;
      r_cy    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        r_instr <= bus.INSTR[31:4];
        r_k     <= bus.K_IN;
        r_daddr <= bus.DADDR_IN;
      end
      if (r_state == S_WB)
        r_cy <= bus.CY_OUT;
    end
  end

  always_comb begin
    w_nxt           = r_state;
    bus.INSTR_READY = 1'b0;
    bus.ALUC_IN     = '0;
    bus.Shifter_Sel = '0;
    bus.Y_X_Kmx_Sel = 1'b0;
    bus.SEL_A_RB    = '0;
    bus.SEL_B_RB    = '0;
    bus.C_SEL_RB    = '0;
    bus.Y_KMx_IN    = '0;
    bus.DAddr       = '0;
    bus.CY_IN       = 1'b0;
    bus.Rd          = 1'b0;
    bus.Wr          = 1'b0;
    bus.DONE        = 1'b0;
    bus.ERR         = 1'b0;

    if (r_state != S_IDLE) begin
      bus.ALUC_IN     = r_instr[27:24];
      bus.Shifter_Sel = r_instr[23:22];
      bus.Y_X_Kmx_Sel = r_instr[21];
      bus.SEL_A_RB    = r_instr[18:13];
      bus.SEL_B_RB    = r_instr[12:7];
      bus.C_SEL_RB    = r_instr[6:1];
      bus.Y_KMx_IN    = r_k;
      bus.DAddr       = r_daddr;
      bus.CY_IN       = r_instr[0] & r_cy;
    end

    case (r_state)
      S_IDLE: begin
        bus.INSTR_READY = 1'b1;
        if (bus.INSTR_VALID)
          w_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (w_mem == 2'b01)
          w_nxt = S_MEMRD;
        else if (w_mem == 2'b10)
          w_nxt = S_MEMWR;
        else
          w_nxt = S_WB;
      end
      S_MEMRD: begin
        bus.Rd = 1'b1;
        w_nxt  = S_WB;
      end
      S_MEMWR: begin
        bus.Wr = 1'b1;
        w_nxt  = S_WB;
      end
      S_WB: begin
        bus.DONE = 1'b1;
        bus.ERR  = (w_mem == 2'b11);
        w_nxt    = S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/alu_seq_ctrl.md
ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 SHALL have ports: CLK  in  1  sole clock, rising edge.
REQ-002 SHALL have: RST  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: INSTR_VALID  in  1  requester offers INSTR/K_IN/DADDR_IN.
REQ-004 SHALL have: INSTR_READY  out  1  controller accepts this cycle.
REQ-005 SHALL have: INSTR  in  32  operation word (fields below).
REQ-006 SHALL have: K_IN  in  16  constant operand; DADDR_IN  in  10  data-memory address.
REQ-007 SHALL have: Y_KMx_IN out 16, DAddr out 10, Y_X_Kmx_Sel out 1, Shifter_Sel out 2, ALUC_IN out 4, CY_IN out 1, SEL_A_RB out 6, SEL_B_RB out 6, C_SEL_RB out 6, Rd out 1, Wr out 1  datapath controls.
REQ-008 SHALL have: CY_OUT  in  1  datapath carry out.
REQ-009 SHALL have: DONE out 1 completion pulse; ERR out 1 reserved-field pulse; CY_FLAG out 1 stored carry.

Function
REQ-010 INSTR fields SHALL be: [31:28] ALUC, [27:26] SHIFT, [25] KSEL, [24:23] MEM (00 none, 01 load, 10 store, 11 reserved), [22:17] A, [16:11] B, [10:5] C, [4] CYUSE, [3:0] ignored.
REQ-011 States SHALL be IDLE, EXEC, MEMRD, MEMWR, WB.
REQ-012 INSTR_READY SHALL be 1 only in IDLE (combinational from state).
REQ-013 Accept = INSTR_VALID & INSTR_READY at a rising edge; INSTR, K_IN, DADDR_IN SHALL be latched into internal registers then; IDLE -> EXEC.
REQ-014 EXEC -> MEMRD if MEM=01, MEMWR if MEM=10, else WB; MEMRD/MEMWR -> WB; WB -> IDLE; each state lasts exactly one cycle.
REQ-015 From EXEC through WB inclusive, datapath outputs SHALL be held constant from latched fields: ALUC_IN=ALUC, Shifter_Sel=SHIFT, Y_X_Kmx_Sel=KSEL, SEL_A_RB=A, SEL_B_RB=B, C_SEL_RB=C, Y_KMx_IN=latched K, DAddr=latched DADDR.
REQ-016 CY_IN SHALL equal CY_FLAG when CYUSE=1, else 0, during EXEC..WB.
REQ-017 Rd SHALL be 1 only in MEMRD; Wr SHALL be 1 only in MEMWR; never both.
REQ-018 In WB, CY_FLAG SHALL load CY_OUT at the WB->IDLE edge; CY_FLAG otherwise holds.
REQ-019 DONE SHALL be 1 for exactly the WB cycle.
REQ-020 MEM=11 SHALL be treated as none (EXEC -> WB) and ERR SHALL be 1 during that WB cycle; otherwise ERR=0.
REQ-021 In IDLE all datapath outputs SHALL be 0.
REQ-022 Latency: non-memory op = 2 cycles after accept (EXEC, WB); memory op = 3 cycles; INSTR_READY returns 1 the cycle after WB, so minimum accept spacing is 3 (non-mem) / 4 (mem) cycles.
REQ-023 INSTR_VALID while INSTR_READY=0 SHALL be ignored without side effects; requester holds it.
REQ-024 Input changes on INSTR/K_IN/DADDR_IN after accept SHALL not affect the op in flight.

Reset
REQ-025 RST=1 SHALL immediately force state IDLE and all outputs to 0 except INSTR_READY=1; CY_FLAG=0; latched fields=0.
REQ-026 RST asserted mid-operation (incl. MEMRD/MEMWR) SHALL drop Rd/Wr asynchronously with no DONE pulse; the aborted op is lost.
REQ-027 First accept possible at first rising edge after RST deasserts.

Verification
REQ-028 ALU op: INSTR ALUC=3, A=1, B=2, C=5, MEM=00, VALID 1 cycle -> EXEC/WB outputs ALUC_IN=3, SEL_A_RB=1, SEL_B_RB=2, C_SEL_RB=5; DONE at cycle 2; Rd=Wr=0.
REQ-029 Load: MEM=01, DADDR_IN=0x155 -> Rd=1 only in cycle 2, DAddr=0x155 cycles 1-3, DONE cycle 3.
REQ-030 Carry chain: op1 with CY_OUT=1 in WB, op2 CYUSE=1 -> CY_IN=1 during op2 EXEC..WB, CY_FLAG=1; op2 CYUSE=0 -> CY_IN=0.
REQ-031 Busy/back-to-back: VALID held high continuously, INSTR changed during EXEC -> second accept only after WB, in-flight fields unchanged.
REQ-032 Reserved MEM=11 -> no Rd/Wr, ERR=1 and DONE=1 in cycle 2.
REQ-033 RST pulse during MEMWR -> Wr=0 same cycle, INSTR_READY=1, no DONE, CY_FLAG=0.
